// File: rtl/pll_cen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Holds the sequencing FSM states and the settle-counter sizing helper.
package pll_cen_pkg;

   localparam int DEF_ACC_W      = 16;
   localparam int DEF_SETTLE_CYC = 1024;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } cen_state_t;

   // Bits needed to count 0..value-1; never narrower than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/cen_accum.sv
// One enable channel: latched increment, phase accumulator and a
// registered, mask-gated carry pulse.
module cen_accum
   import pll_cen_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             load,
   input  logic [ACC_W-1:0] inc_in,
   input  logic             mask,
   output logic             cen
);

   logic [ACC_W-1:0] inc_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W:0]   sum;

   // One extra bit so the wrap-around carry is the pulse itself.
   assign sum = {1'b0, acc_q} + {1'b0, inc_q};

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         inc_q <= '0;
         acc_q <= '0;
         cen   <= 1'b0;
      end else begin
         if (load) inc_q <= inc_in;
         // Any non-advancing cycle parks the phase at zero, so every
         // channel restarts aligned after a load or a lock event.
         acc_q <= advance ? sum[ACC_W-1:0] : '0;
         cen   <= advance & sum[ACC_W] & mask;
      end
   end

endmodule

// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator on the fast PLL clock.
// Sequences start-up from PLL lock and realigns channel phases on load.
module pll_cen_gen
   import pll_cen_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
   input  logic [NUM_CH-1:0]       cfg_mask,
   input  logic                    cfg_load,
   output logic [NUM_CH-1:0]       cen,
   output logic                    run,
   output logic                    lock_lost
);

   localparam int              CNT_W       = clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   cen_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   lock_drop;
   logic                   advance;

   // NOTE: non-blocking assignments make each stage take the previous
   // stage's old value, which is what gives a real multi-flop chain.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a
      // signal unassigned and infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s) state_d = SETTLE;
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == SETTLE_LAST) state_d = RUN;
            end
         end
         RUN: begin
            if (!lock_s) state_d = WAIT_LOCK;
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   assign run       = (state_q == RUN);
   assign lock_drop = (state_q == RUN) && !lock_s;
   assign advance   = (state_q == RUN) && lock_s && !cfg_load;

   // Lock loss takes priority so a coincident load cannot hide it.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)         lock_lost <= 1'b0;
      else if (lock_drop) lock_lost <= 1'b1;
      else if (cfg_load)  lock_lost <= 1'b0;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cen_accum #(
         .ACC_W (ACC_W)
      ) u_ch (
         .refclk  (refclk),
         .rst_n   (rst_n),
         .advance (advance),
         .load    (cfg_load),
         .inc_in  (cfg_inc[g*ACC_W +: ACC_W]),
         .mask    (cfg_mask[g]),
         .cen     (cen[g])
      );
   end

endmodule
